// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the arbitrated ALU: operation codes and arbiter FSM states.
package alu_share_arbiter_pkg;

  localparam int CTRL_W = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared by all requesters; codes outside the table produce zero.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [WIDTH-1:0]  out_o,
  output logic              zero_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] res;

  assign sh = b_i[SHW-1:0];

  // Operation decode
  always_comb begin
    res = '0;
    case (ctrl_i)
      ALU_ADD:  res = a_i + b_i;
      ALU_SUB:  res = a_i - b_i;
      ALU_AND:  res = a_i & b_i;
      ALU_OR:   res = a_i | b_i;
      ALU_SLL:  res = a_i << sh;
      ALU_SLT:  res = ($signed(a_i) < $signed(b_i)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      ALU_SRL:  res = a_i >> sh;
      ALU_XOR:  res = a_i ^ b_i;
      ALU_SRA:  res = $unsigned($signed(a_i) >>> sh);
      ALU_SLTU: res = (a_i < b_i) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      default:  res = '0;
    endcase
  end

  assign out_o  = res;
  assign zero_o = (res == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, one operation in flight,
// with the registered result held until the owning requester takes it.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ*CTRL_W-1:0]   req_ctrl,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_zero,
  output logic                     busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    rr_ptr_d;
  logic [IDW-1:0]    gnt_idx_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [WIDTH-1:0]  rsp_data_q;
  logic              rsp_zero_q;

  logic [IDW-1:0]    win;
  logic              fire;
  logic              accept;
  logic [WIDTH-1:0]  win_a;
  logic [WIDTH-1:0]  win_b;
  logic [CTRL_W-1:0] win_ctrl;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_zero;

  // First valid index at or after ptr, wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] ptr);
    logic found;
    int   j;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end else begin
        j = j;
      end
      if (!found && v[j]) begin
        rr_pick = IDW'(j);
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Arbitration, accept decision and the one-hot ready; nothing is accepted while in reset.
  always_comb begin
    win       = rr_pick(req_valid, rr_ptr_q);
    fire      = (state_q == ST_RESP) && rsp_ready[gnt_idx_q];
    accept    = rst_n && (|req_valid) && ((state_q == ST_IDLE) || fire);
    req_ready = '0;
    if (accept) begin
      req_ready[win] = 1'b1;
    end else begin
      req_ready = '0;
    end
    if (win == IDW'(NREQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = win + IDW'(1);
    end
    win_a    = req_a[int'(win)*WIDTH +: WIDTH];
    win_b    = req_b[int'(win)*WIDTH +: WIDTH];
    win_ctrl = req_ctrl[int'(win)*CTRL_W +: CTRL_W];
  end

  alu_share_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .ctrl_i (ctrl_q),
    .out_o  (alu_out),
    .zero_o (alu_zero)
  );

  // Arbiter FSM: IDLE -> EXEC -> RESP -> IDLE, or RESP -> EXEC when a new op is taken on fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            a_q         <= win_a;
            b_q         <= win_b;
            ctrl_q      <= win_ctrl;
            gnt_idx_q   <= win;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= '0;
            state_q     <= ST_EXEC;
          end else if (fire) begin
            rsp_valid_q <= '0;
            state_q     <= ST_IDLE;
          end else begin
            state_q     <= state_q;
          end
        end
        ST_EXEC: begin
          rsp_data_q  <= alu_out;
          rsp_zero_q  <= alu_zero;
          rsp_valid_q <= NREQ'(1) << gnt_idx_q;
          state_q     <= ST_RESP;
        end
        default: begin
          rsp_valid_q <= '0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two 32-bit requesters.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_ctrl;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_share_arbiter #(.WIDTH(32), .NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctrl  (req_ctrl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_ctrl[idx*4 +: 4] = c;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_ctrl = '0;
    cyc(); cyc();
    total_cnt++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b exp 00", req_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b exp 00", rsp_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h exp 0", rsp_data); else pass_cnt++;
    total_cnt++; if (rsp_zero !== 1'b0) $display("FAIL reset_rsp_zero: got %b exp 0", rsp_zero); else pass_cnt++;
    req_valid = 2'b00;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_op;
    set_req(0, 32'd5, 32'd7, 4'b0000);
    req_valid = 2'b01;
    #1;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL single_accept: got %b exp 01", req_ready); else pass_cnt++;
    cyc();
    req_valid = 2'b00;
    set_req(0, 32'd100, 32'd100, 4'b0001);
    #1;
    total_cnt++; if (busy !== 1'b1 || rsp_valid !== 2'b00) $display("FAIL single_exec: got busy=%b rsp_valid=%b exp 1/00", busy, rsp_valid); else pass_cnt++;
    cyc();
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (rsp_valid !== 2'b01 || rsp_data !== 32'd12 || rsp_zero !== 1'b0)
        $display("FAIL single_hold%0d: got v=%b d=%h z=%b exp 01/0000000c/0", i, rsp_valid, rsp_data, rsp_zero);
      else pass_cnt++;
      if (i < 3) cyc();
    end
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
    total_cnt++; if (rsp_valid !== 2'b00 || busy !== 1'b0) $display("FAIL single_release: got v=%b busy=%b exp 00/0", rsp_valid, busy); else pass_cnt++;
  endtask

  task automatic test_zero_sra;
    set_req(1, 32'd5, 32'd5, 4'b0001);
    req_valid = 2'b10;
    #1;
    total_cnt++; if (req_ready !== 2'b10) $display("FAIL sub_accept: got %b exp 10", req_ready); else pass_cnt++;
    cyc();
    req_valid = 2'b00;
    cyc();
    total_cnt++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h0 || rsp_zero !== 1'b1) $display("FAIL sub_zero: got v=%b d=%h z=%b exp 10/0/1", rsp_valid, rsp_data, rsp_zero); else pass_cnt++;
    set_req(1, 32'h80000000, 32'd4, 4'b1000);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    #1;
    total_cnt++; if (req_ready !== 2'b10) $display("FAIL sra_b2b_accept: got %b exp 10", req_ready); else pass_cnt++;
    cyc();
    req_valid = 2'b00; rsp_ready = 2'b00;
    total_cnt++; if (rsp_valid !== 2'b00 || busy !== 1'b1) $display("FAIL sra_exec: got v=%b busy=%b exp 00/1", rsp_valid, busy); else pass_cnt++;
    cyc();
    total_cnt++; if (rsp_valid !== 2'b10 || rsp_data !== 32'hF8000000 || rsp_zero !== 1'b0) $display("FAIL sra_result: got v=%b d=%h z=%b exp 10/f8000000/0", rsp_valid, rsp_data, rsp_zero); else pass_cnt++;
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = 2'b00;
  endtask

  task automatic test_fairness;
    logic [1:0]  rr_exp [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [1:0]  rv_exp [7] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [31:0] d_exp  [7] = '{32'd0, 32'd0, 32'd3, 32'd0, 32'd7, 32'd0, 32'd3};
    set_req(0, 32'd1, 32'd2, 4'b0000);
    set_req(1, 32'd10, 32'd3, 4'b0001);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 7; i++) begin
      #1;
      total_cnt++;
      if (req_ready !== rr_exp[i] || rsp_valid !== rv_exp[i] || (rv_exp[i] != 2'b00 && rsp_data !== d_exp[i]))
        $display("FAIL fair_c%0d: got rdy=%b v=%b d=%h exp %b/%b/%h", i, req_ready, rsp_valid, rsp_data, rr_exp[i], rv_exp[i], d_exp[i]);
      else pass_cnt++;
      if (i == 6) req_valid = 2'b00;
      cyc();
    end
    rsp_ready = 2'b00;
    total_cnt++; if (busy !== 1'b0 || rsp_valid !== 2'b00) $display("FAIL fair_idle: got busy=%b v=%b exp 0/00", busy, rsp_valid); else pass_cnt++;
  endtask

  task automatic test_wrong_ready;
    set_req(0, 32'd9, 32'd6, 4'b0111);
    req_valid = 2'b01;
    #1;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL wr_accept: got %b exp 01", req_ready); else pass_cnt++;
    cyc();
    req_valid = 2'b00;
    cyc();
    rsp_ready = 2'b10;
    cyc();
    total_cnt++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd15 || busy !== 1'b1) $display("FAIL wr_no_fire: got v=%b d=%h busy=%b exp 01/0000000f/1", rsp_valid, rsp_data, busy); else pass_cnt++;
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
    total_cnt++; if (rsp_valid !== 2'b00 || busy !== 1'b0) $display("FAIL wr_fire: got v=%b busy=%b exp 00/0", rsp_valid, busy); else pass_cnt++;
  endtask

  task automatic test_reset_midop;
    set_req(0, 32'd3, 32'd4, 4'b0000);
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0 || rsp_valid !== 2'b00) $display("FAIL midrst_busy: got busy=%b v=%b exp 0/00", busy, rsp_valid); else pass_cnt++;
    cyc();
    rst_n = 1'b1;
    cyc();
    total_cnt++; if (rsp_valid !== 2'b00 || busy !== 1'b0) $display("FAIL midrst_no_rsp: got v=%b busy=%b exp 00/0", rsp_valid, busy); else pass_cnt++;
    set_req(0, 32'd123, 32'd45, 4'b1111);
    set_req(1, 32'd1, 32'd1, 4'b0000);
    req_valid = 2'b11;
    #1;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL midrst_rrptr: got %b exp 01", req_ready); else pass_cnt++;
    cyc();
    req_valid = 2'b00;
    cyc();
    total_cnt++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h0 || rsp_zero !== 1'b1) $display("FAIL illegal_ctrl: got v=%b d=%h z=%b exp 01/0/1", rsp_valid, rsp_data, rsp_zero); else pass_cnt++;
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_zero_sra();
    test_fairness();
    test_wrong_ready();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
